instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch-side initiator for the combinational, word-addressed instruction memory. It owns the fetch PC and drives the byte address to the memory. The memory returns the 32-bit word in the same cycle. The unit buffers returned words with their PCs in a small in-order queue and presents them to decode over a valid/ready handshake. It also handles PC redirects from branch resolution and flags misaligned or out-of-range fetches instead of issuing them.

Parameters:
MEM_SIZE, 1024, instruction memory size in bytes; power of two, greater than 4.
QUEUE_DEPTH, 2, fetch-queue entries; power of two, at least 2.
RESET_PC, 0, fetch PC loaded on reset; word-aligned.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
imem_address  output  64  byte address to instruction memory; always equals fetch_pc.
imem_instruction  input  32  word returned combinationally for imem_address.
redirect_valid  input  1  load redirect_pc as the new fetch PC and flush the queue.
redirect_pc  input  64  redirect target byte address.
out_valid  output  1  queue head holds a valid instruction.
out_instruction  output  32  queue head instruction; 0 when out_valid is 0.
out_pc  output  64  queue head PC; 0 when out_valid is 0.
out_ready  input  1  decode accepts head this cycle.
fault  output  1  fetch halted on a misaligned or out-of-range PC.
fault_pc  output  64  offending fetch_pc; valid while fault is 1.

Behaviour:
- Reset (async, any time, including mid-operation):
  - fetch_pc = RESET_PC; queue empty (count 0, read and write pointers 0); state FETCH.
  - Outputs: out_valid 0, out_instruction 0, out_pc 0, fault 0, fault_pc 0, imem_address = RESET_PC.
- Legality: a fetch is legal when fetch_pc[1:0] == 0 and fetch_pc + 3 < MEM_SIZE. Compare at full 64-bit width; no truncation or wrap of the address.
- pop = out_valid && out_ready. Head advances at the posedge.
- push = (state == FETCH) && !redirect_valid && legal && (count < QUEUE_DEPTH || pop).
  - Push writes {fetch_pc, imem_instruction} at the tail; fetch_pc <= fetch_pc + 4.
  - Simultaneous push and pop on a full queue is allowed; count is unchanged.
- Load-to-use latency: an instruction fetched into an empty queue has out_valid = 1 in the next cycle. Sustained throughput is one instruction per cycle while out_ready is held at 1.
- Back-pressure: when the queue is full and there is no pop, fetch_pc holds and imem_address is stable.
- State machine, two states:
  - FETCH -> FAULT when no redirect, fetch_pc is illegal, and the cycle would otherwise fetch. Capture fault_pc <= fetch_pc.
  - FAULT: no pushes; fetch_pc holds. Queued entries still drain normally. fault = (state == FAULT). The state is sticky.
  - FAULT -> FETCH only on redirect_valid. fault and fault_pc clear to 0 at the same edge.
- Redirect has priority over every other event in the cycle:
  - Queue flushes to empty and fetch_pc <= redirect_pc; no push that cycle.
  - A pop in the same cycle is a completed handshake for decode, but the entry is discarded by the flush.
  - out_valid is 0 in the cycle after any redirect.
  - Legality of redirect_pc is evaluated on the following cycle via the normal rule. A misaligned target therefore faults with fault_pc = redirect_pc.
- Sequential fetch past the end: fetching the last word (MEM_SIZE-4) is legal. The next PC (MEM_SIZE) faults.
- All outputs are registered or derived only from registered state, except imem_address, which is fetch_pc directly.

Test Plan:
- Reset, out_ready = 1, memory holding word i = 0x1000_0000 + i -> imem_address steps 0, 4, 8, ... per cycle; out_valid is first 1 in cycle 2 with out_pc 0, out_instruction 0x1000_0000; one instruction per cycle thereafter.
- out_ready = 0 for 5 cycles after reset -> queue fills to 2 entries (PC 0, PC 4); imem_address holds at 8; on release, the output sequence is 0, 4, 8 with no gaps or duplicates.
- redirect_valid pulse with redirect_pc = 0x40 while the queue is full -> next cycle out_valid = 0 and imem_address = 0x40; the following cycle out_pc = 0x40.
- Fetch runs sequentially to 0x3FC with MEM_SIZE = 1024 -> PC 0x3FC is delivered; then fault = 1, fault_pc = 0x400, no further pushes; a redirect to 0 clears fault and fetch resumes at 0.
- Redirect to 0x42 -> fault = 1, fault_pc = 0x42 two cycles after the pulse; out_valid stays 0.
- Assert reset for one cycle mid-stream with the queue holding 2 entries -> out_valid, fault, out_pc, fault_pc go to 0 immediately; imem_address = RESET_PC; fetch restarts from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the combinational
// instruction memory and buffers fetched words with their PCs in a small
// in-order queue that drains to decode over a valid/ready handshake.
// Misaligned or out-of-range PCs halt fetch in a sticky FAULT state.
// Only a redirect leaves FAULT.
module instr_fetch_unit #(
  parameter int unsigned MEM_SIZE    = 1024,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [63:0] RESET_PC    = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instruction,
  output logic [63:0] out_pc,
  input  logic        out_ready,
  output logic        fault,
  output logic [63:0] fault_pc
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);
  localparam logic [64:0]      MEM_END  = 65'(MEM_SIZE);

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        fetchPc_q, fetchPc_d;
  logic [63:0]        faultPc_q, faultPc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;

  logic [63:0]        pcStore    [QUEUE_DEPTH];
  logic [31:0]        instrStore [QUEUE_DEPTH];

  logic [64:0]        lastByte;
  logic               legal;
  logic               headValid;
  logic               pop;
  logic               wantFetch;
  logic               push;
  logic               goFault;

  // The last byte of the word is computed one bit wider so a PC near the
  // top of the 64-bit space cannot wrap around and look in range.
  assign lastByte  = {1'b0, fetchPc_q} + 65'd3;
  assign legal     = (fetchPc_q[1:0] == 2'b00) && (lastByte < MEM_END);

  assign headValid = (count_q != '0);
  assign pop       = headValid && out_ready;
  // A fetch would happen this cycle if the PC turned out to be legal.
  assign wantFetch = (state_q == FETCH) && !redirect_valid
                     && ((count_q < DEPTH_C) || pop);
  assign push      = wantFetch && legal;
  assign goFault   = wantFetch && !legal;

  assign imem_address    = fetchPc_q;
  assign out_valid       = headValid;
  assign out_instruction = headValid ? instrStore[rdPtr_q] : 32'd0;
  assign out_pc          = headValid ? pcStore[rdPtr_q] : 64'd0;
  assign fault           = (state_q == FAULT);
  assign fault_pc        = faultPc_q;

  // Next-state logic: redirect flushes everything and wins over any
  // push, pop or fault detection in the same cycle.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    faultPc_d = faultPc_q;
    count_d   = count_q;
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    if (redirect_valid) begin
      state_d   = FETCH;
      fetchPc_d = redirect_pc;
      faultPc_d = 64'd0;
      count_d   = '0;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
    end else begin
      if (push) begin
        wrPtr_d   = wrPtr_q + PTR_W'(1);
        fetchPc_d = fetchPc_q + 64'd4;
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
      if (goFault) begin
        state_d   = FAULT;
        faultPc_d = fetchPc_q;
      end
    end
  end

  // State, PC and queue bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      fetchPc_q <= RESET_PC;
      faultPc_q <= 64'd0;
      count_q   <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      faultPc_q <= faultPc_d;
      count_q   <= count_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
    end
  end

  // Queue storage; contents are only visible through a nonzero count, so
  // the entries themselves need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pcStore[wrPtr_q]    <= fetchPc_q;
      instrStore[wrPtr_q] <= imem_instruction;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a combinational memory
// model whose word i holds 0x1000_0000 + i.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imemAddress;
  logic [31:0] imemInstruction;
  logic        redirectValid;
  logic [63:0] redirectPc;
  logic        outValid;
  logic [31:0] outInstruction;
  logic [63:0] outPc;
  logic        outReady;
  logic        fault;
  logic [63:0] faultPc;

  int assertCount = 0;
  int failCount   = 0;

  instr_fetch_unit #(
    .MEM_SIZE(1024),
    .QUEUE_DEPTH(2),
    .RESET_PC(64'd0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_address(imemAddress),
    .imem_instruction(imemInstruction),
    .redirect_valid(redirectValid),
    .redirect_pc(redirectPc),
    .out_valid(outValid),
    .out_instruction(outInstruction),
    .out_pc(outPc),
    .out_ready(outReady),
    .fault(fault),
    .fault_pc(faultPc)
  );

  // Memory model: word index = byte address / 4.
  assign imemInstruction = 32'h1000_0000 + 32'(imemAddress[31:2]);

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [63:0] rpc, input logic rdy);
    redirectValid = rv;
    redirectPc    = rpc;
    outReady      = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 64'd0, 1'b1);
    #3;
    checkOutput("rst_valid", 64'(outValid), 64'd0);
    checkOutput("rst_instr", 64'(outInstruction), 64'd0);
    checkOutput("rst_pc", outPc, 64'd0);
    checkOutput("rst_fault", 64'(fault), 64'd0);
    checkOutput("rst_faultpc", faultPc, 64'd0);
    checkOutput("rst_addr", imemAddress, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Streaming with out_ready held high.
    for (int k = 1; k <= 6; k++) begin
      step();
      checkOutput("str_addr", imemAddress, 64'(4 * k));
      checkOutput("str_valid", 64'(outValid), 64'd1);
      checkOutput("str_pc", outPc, 64'(4 * (k - 1)));
      checkOutput("str_instr", 64'(outInstruction), 64'(32'h1000_0000 + k - 1));
    end

    // Back-pressure after a fresh reset.
    reset = 1'b1;
    #1;
    checkOutput("bp_rst_valid", 64'(outValid), 64'd0);
    checkOutput("bp_rst_addr", imemAddress, 64'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      checkOutput("bp_addr", imemAddress, (k == 1) ? 64'd4 : 64'd8);
      checkOutput("bp_pc", outPc, 64'd0);
      checkOutput("bp_valid", 64'(outValid), 64'd1);
    end
    applyStimulus(1'b0, 64'd0, 1'b1);
    step();
    checkOutput("bp_rel_pc4", outPc, 64'h4);
    checkOutput("bp_rel_addr12", imemAddress, 64'hC);
    step();
    checkOutput("bp_rel_pc8", outPc, 64'h8);
    checkOutput("bp_rel_addr16", imemAddress, 64'h10);
    step();
    checkOutput("bp_rel_pc12", outPc, 64'hC);

    // Redirect while the queue is full.
    applyStimulus(1'b0, 64'd0, 1'b0);
    step();
    step();
    applyStimulus(1'b1, 64'h40, 1'b0);
    step();
    checkOutput("rd_valid", 64'(outValid), 64'd0);
    checkOutput("rd_addr", imemAddress, 64'h40);
    applyStimulus(1'b0, 64'd0, 1'b0);
    step();
    checkOutput("rd_valid2", 64'(outValid), 64'd1);
    checkOutput("rd_pc", outPc, 64'h40);
    checkOutput("rd_instr", 64'(outInstruction), 64'h1000_0010);
    checkOutput("rd_addr2", imemAddress, 64'h44);

    // Sequential fetch off the end of memory.
    applyStimulus(1'b1, 64'h3F0, 1'b1);
    step();
    checkOutput("end_valid0", 64'(outValid), 64'd0);
    checkOutput("end_addr0", imemAddress, 64'h3F0);
    applyStimulus(1'b0, 64'd0, 1'b1);
    step();
    checkOutput("end_pc3f0", outPc, 64'h3F0);
    step();
    checkOutput("end_pc3f4", outPc, 64'h3F4);
    step();
    checkOutput("end_pc3f8", outPc, 64'h3F8);
    step();
    checkOutput("end_pc3fc", outPc, 64'h3FC);
    checkOutput("end_instr3fc", 64'(outInstruction), 64'h1000_00FF);
    checkOutput("end_addr400", imemAddress, 64'h400);
    checkOutput("end_nofault", 64'(fault), 64'd0);
    step();
    checkOutput("end_fault", 64'(fault), 64'd1);
    checkOutput("end_faultpc", faultPc, 64'h400);
    checkOutput("end_valid", 64'(outValid), 64'd0);
    checkOutput("end_addr_hold", imemAddress, 64'h400);
    step();
    checkOutput("end_sticky", 64'(fault), 64'd1);
    checkOutput("end_nopush", 64'(outValid), 64'd0);
    applyStimulus(1'b1, 64'd0, 1'b1);
    step();
    checkOutput("clr_fault", 64'(fault), 64'd0);
    checkOutput("clr_faultpc", faultPc, 64'd0);
    checkOutput("clr_addr", imemAddress, 64'd0);
    checkOutput("clr_valid", 64'(outValid), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b1);
    step();
    checkOutput("clr_resume_valid", 64'(outValid), 64'd1);
    checkOutput("clr_resume_pc", outPc, 64'd0);

    // Misaligned redirect target.
    applyStimulus(1'b1, 64'h42, 1'b1);
    step();
    checkOutput("mis_addr", imemAddress, 64'h42);
    checkOutput("mis_nofault", 64'(fault), 64'd0);
    checkOutput("mis_valid0", 64'(outValid), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b1);
    step();
    checkOutput("mis_fault", 64'(fault), 64'd1);
    checkOutput("mis_faultpc", faultPc, 64'h42);
    checkOutput("mis_valid1", 64'(outValid), 64'd0);
    step();
    checkOutput("mis_valid2", 64'(outValid), 64'd0);

    // Asynchronous reset clears a fault immediately.
    reset = 1'b1;
    #1;
    checkOutput("arst_fault", 64'(fault), 64'd0);
    checkOutput("arst_faultpc", faultPc, 64'd0);
    checkOutput("arst_addr", imemAddress, 64'd0);
    reset = 1'b0;

    // Asynchronous reset with two queued entries.
    applyStimulus(1'b1, 64'h20, 1'b0);
    step();
    checkOutput("mid_addr", imemAddress, 64'h20);
    applyStimulus(1'b0, 64'd0, 1'b0);
    step();
    step();
    checkOutput("mid_full_pc", outPc, 64'h20);
    checkOutput("mid_full_addr", imemAddress, 64'h28);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 64'(outValid), 64'd0);
    checkOutput("mid_rst_pc", outPc, 64'd0);
    checkOutput("mid_rst_instr", 64'(outInstruction), 64'd0);
    checkOutput("mid_rst_addr", imemAddress, 64'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b1);
    step();
    checkOutput("mid_restart_valid", 64'(outValid), 64'd1);
    checkOutput("mid_restart_pc", outPc, 64'd0);
    checkOutput("mid_restart_addr", imemAddress, 64'd4);
    step();
    checkOutput("mid_restart_pc4", outPc, 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
